// File: rtl/fp16_arb_pkg.sv
// Shared FP16 field widths, zero constant and pipeline-stage record for the
// arbitrated FP16 add/sub unit.
package fp16_arb_pkg;

    localparam int unsigned EXP_W = 5;
    localparam int unsigned MAN_W = 10;
    localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;
    localparam int unsigned ID_W  = 3;

    localparam logic [FP_W-1:0] FP16_ZERO = '0;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [FP_W-1:0] data;
    } stage_t;

endpackage

// File: rtl/fp16_add_core.sv
// Combinational FP16 add/sub: align by exponent difference, 11-bit add or
// subtract, carry adjust or leading-zero normalize. No denormal/NaN/Inf handling.
module fp16_add_core
    import fp16_arb_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            sub,
    output logic [FP_W-1:0] result_c
);

    localparam int unsigned SIG_W = MAN_W + 1;

    logic             sign_a, sign_b, sign_l, a_larger, eff_sub, found;
    logic [EXP_W-1:0] exp_a, exp_b, exp_l, exp_s, exp_diff;
    logic [SIG_W-1:0] sig_a, sig_b, sig_l, sig_s, sig_s_al, diff;
    logic [SIG_W:0]   sum;
    logic [3:0]       lz;
    logic [MAN_W-1:0] norm;

    always_comb begin
        sign_a   = a[FP_W-1];
        sign_b   = b[FP_W-1] ^ sub;
        exp_a    = a[FP_W-2 -: EXP_W];
        exp_b    = b[FP_W-2 -: EXP_W];
        sig_a    = {exp_a != '0, a[MAN_W-1:0]};
        sig_b    = {exp_b != '0, b[MAN_W-1:0]};
        a_larger = a[FP_W-2:0] >= b[FP_W-2:0];

        sign_l   = a_larger ? sign_a : sign_b;
        exp_l    = a_larger ? exp_a  : exp_b;
        exp_s    = a_larger ? exp_b  : exp_a;
        sig_l    = a_larger ? sig_a  : sig_b;
        sig_s    = a_larger ? sig_b  : sig_a;

        exp_diff = exp_l - exp_s;
        sig_s_al = sig_s >> exp_diff;
        eff_sub  = sign_a ^ sign_b;
        sum      = {1'b0, sig_l} + {1'b0, sig_s_al};
        diff     = sig_l - sig_s_al;

        // Leading-zero count of the difference (larger magnitude minus smaller, never negative)
        lz    = '0;
        found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!found && diff[i]) begin
                lz    = 4'(int'(SIG_W) - 1 - i);
                found = 1'b1;
            end
        end
        norm = MAN_W'(diff << lz);

        result_c = FP16_ZERO;
        if (!eff_sub) begin
            if (sum[SIG_W]) result_c = {sign_l, EXP_W'(exp_l + 1'b1), sum[SIG_W-1:1]};
            else            result_c = {sign_l, exp_l, sum[MAN_W-1:0]};
        end else if (diff != '0) begin
            result_c = {sign_l, EXP_W'(exp_l - EXP_W'(lz)), norm};
        end
    end

endmodule

// File: rtl/fp16_add_arbiter.sv
// NREQ requesters share one FP16 add/sub datapath with a LAT-stage pipeline.
// Define FP16_ADD_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module fp16_add_arbiter
    import fp16_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [FP_W*NREQ-1:0] req_a,
    input  logic [FP_W*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]      req_sub,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [FP_W*NREQ-1:0] rsp_data,
    output logic                 busy
);

    localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PIPE_N = (LAT > 1) ? LAT - 1 : 1;

    logic [NREQ-1:0] eligible_c, grant_c, inflight;
    logic [ID_W-1:0] grant_id_c;
    logic [FP_W-1:0] op_a_c, op_b_c, result_c;
    logic            op_sub_c;
    stage_t          head_c, tail;

    // A slot is free when nothing is in flight for it and its held response is gone or leaving now
    assign eligible_c = req_valid & ~inflight & (~rsp_valid | rsp_ready) & {NREQ{rst_n}};
    assign req_ready  = grant_c;

`ifdef FP16_ADD_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (eligible_c[i]) begin
                grant_c    = '0;
                grant_c[i] = 1'b1;
                grant_id_c = ID_W'(i);
            end
        end
    end
`else
    logic [PTR_W-1:0] ptr;
    int               idx;

    // Scan from ptr; walking backwards lets the first requester in search order win
    always_comb begin
        grant_c    = '0;
        grant_id_c = '0;
        idx        = 0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % int'(NREQ);
            if (eligible_c[idx]) begin
                grant_c      = '0;
                grant_c[idx] = 1'b1;
                grant_id_c   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|grant_c) begin
            ptr <= (grant_id_c == ID_W'(NREQ - 1)) ? '0 : PTR_W'(grant_id_c + 1'b1);
        end
    end
`endif

    always_comb begin
        op_a_c   = FP16_ZERO;
        op_b_c   = FP16_ZERO;
        op_sub_c = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_c[i]) begin
                op_a_c   = req_a[i*FP_W +: FP_W];
                op_b_c   = req_b[i*FP_W +: FP_W];
                op_sub_c = req_sub[i];
            end
        end
    end

    fp16_add_core u_core (
        .a        (op_a_c),
        .b        (op_b_c),
        .sub      (op_sub_c),
        .result_c (result_c)
    );

    assign head_c.valid = |grant_c;
    assign head_c.id    = grant_id_c;
    assign head_c.data  = result_c;

    // Stages 1..LAT-1; the response register acts as the final stage
    generate
        if (LAT > 1) begin : g_pipe
            stage_t pipe [PIPE_N];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < int'(PIPE_N); s++) pipe[s] <= '0;
                end else begin
                    pipe[0] <= head_c;
                    for (int s = 1; s < int'(PIPE_N); s++) pipe[s] <= pipe[s-1];
                end
            end

            always_comb begin
                inflight = '0;
                for (int s = 0; s < int'(PIPE_N); s++) begin
                    for (int i = 0; i < int'(NREQ); i++) begin
                        if (pipe[s].valid && pipe[s].id == ID_W'(i)) inflight[i] = 1'b1;
                    end
                end
            end

            assign tail = pipe[PIPE_N-1];
        end else begin : g_direct
            assign tail     = head_c;
            assign inflight = '0;
        end
    endgenerate

    // Response slots hold until consumed; a new arrival never finds its slot occupied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (tail.valid && tail.id == ID_W'(i)) begin
                    rsp_valid[i]                <= 1'b1;
                    rsp_data[i*FP_W +: FP_W]    <= tail.data;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i]                <= 1'b0;
                end
            end
        end
    end

    assign busy = (|inflight) | (|rsp_valid);

endmodule

// File: doc/fp16_add_arbiter.md
FP16_ADD_ARBITER -- requirements
Module: fp16_add_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter LAT, default 2: accept-to-response latency in cycles, range 1..4.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 req_valid  input  NREQ: requester i has an operation pending.
REQ-006 req_ready  output  NREQ: operation of requester i is accepted this cycle.
REQ-007 req_a  input  16*NREQ: FP16 operand A, slice i belongs to requester i.
REQ-008 req_b  input  16*NREQ: FP16 operand B, slice i belongs to requester i.
REQ-009 req_sub  input  NREQ: 1 = A-B, 0 = A+B.
REQ-010 rsp_valid  output  NREQ: result for requester i is held.
REQ-011 rsp_ready  input  NREQ: requester i consumes its result.
REQ-012 rsp_data  output  16*NREQ: FP16 result {sign, exp[4:0], mant[9:0]}.
REQ-013 busy  output  1: an operation is in flight or any rsp_valid is high.

Function
REQ-014 One shared FP16 add/sub datapath; at most one operation is accepted per cycle.
REQ-015 Requester i is eligible when req_valid[i]=1, it has no operation in flight, and rsp_valid[i]=0 or rsp_ready[i]=1 in the same cycle.
REQ-016 Grant is round-robin among eligible requesters: search starts at pointer ptr; after a grant to i, ptr becomes (i+1) mod NREQ; ptr is unchanged when there is no grant.
REQ-017 req_ready is one-hot or zero, is combinational from req_valid and state, and a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-018 An accepted operand set passes through LAT pipeline stages, each carrying valid, requester id and data; the datapath result is registered in stage 1.
REQ-019 An operation accepted at cycle t raises rsp_valid[id] at t+LAT with rsp_data[id] equal to the datapath result.
REQ-020 rsp_valid[i] and rsp_data[i] hold until rsp_valid[i] and rsp_ready[i] are both 1; the pipeline never stalls, because REQ-015 guarantees a free response slot.
REQ-021 A response and a new grant to the same requester may occur in the same cycle.
REQ-022 Datapath arithmetic: align by exponent difference, 11-bit mantissa add or subtract, carry adjust (+1 exponent) on add, leading-zero normalize with exponent decrement on subtract; result sign is the sign of the larger-magnitude operand.
REQ-023 Datapath boundaries: an exact-cancel result is 0x0000; denormals and NaN/Inf are not handled; exponent wrap is not saturated.

Reset
REQ-024 While rst_n=0: all stage valids=0, ptr=0, rsp_valid=0, rsp_data=0, req_ready=0, busy=0.
REQ-025 An assertion of rst_n mid-operation discards all in-flight operations and held responses; none is delivered after deassertion.

Configuration
REQ-026 With FP16_ADD_ARB_FIXED_PRIO_EN defined, the grant goes to the lowest-index eligible requester and ptr is removed; without it, the round-robin rule of REQ-016 applies.

Structure
REQ-027 Package fp16_arb_pkg holds the FP16 field widths (EXP_W=5, MAN_W=10), the FP16 zero constant and the pipeline-stage record typedef (valid, id, data).
REQ-028 The datapath is the combinational sub-module fp16_add_core (align, add/sub, normalize), instantiated once.

Verification
REQ-029 Requester 0 sends 0x3C00 + 0x3C00 -> rsp_data[0]=0x4000 exactly LAT cycles after the accept.
REQ-030 Requester 2 sends 0x4000 - 0x3C00 (sub=1) -> 0x3C00; 0x3C00 - 0x3C00 -> 0x0000.
REQ-031 All 4 requesters are valid from reset with rsp_ready all 1 -> grants 0,1,2,3 on consecutive cycles, then the order repeats.
REQ-032 rsp_ready[1]=0 for 10 cycles with req_valid[1] held -> requester 1 is not re-granted, the others keep being served, and the held rsp_data[1] stays stable.
REQ-033 rst_n is pulsed low with 2 operations in flight -> no rsp_valid is raised afterwards and busy=0.
REQ-034 With FP16_ADD_ARB_FIXED_PRIO_EN and requesters 0 and 3 continuously valid -> requester 0 wins every cycle in which it is eligible.
